// File: rtl/div_pkg.sv
// Shared definitions for the restoring-divider control block:
// state encoding, default operand width and iteration-counter width.
package div_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } div_state_t;

    // Counter must hold the value WIDTH itself, hence WIDTH+1.
    function automatic int div_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_iter_counter.sv
// Loadable down-counter for the shift/compare iterations. is_one marks the
// final iteration so the FSM can leave CHECK on the same edge that consumes it.
module div_iter_counter #(
    parameter int CNT_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             is_one
);

    logic [CNT_W-1:0] count;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign is_one = (count == CNT_W'(1));

endmodule

// File: rtl/div_control_fsm.sv
// Control FSM for the restoring divider.
// state | meaning
// IDLE  | waiting for START; ERR holds the last divide-by-zero verdict
// LOAD  | datapath load/clear (INIT)
// SHIFT | shift {A,DV} left
// CHECK | compare; quotient bit and optional A load from the subtractor
// DONE  | one-cycle completion pulse
module div_control_fsm
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = div_cnt_w(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] DVSR,
    input  logic             MSB,
    output logic             INIT,
    output logic             SH,
    output logic             LDA,
    output logic             DV0,
    output logic             Z,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    div_state_t state;
    div_state_t state_nxt;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_one;
    logic       accept;

    assign accept = (state == ST_IDLE) && START;

    div_iter_counter #(
        .CNT_W (CNT_W)
    ) u_iter_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (CNT_W'(WIDTH)),
        .is_one   (cnt_one)
    );

    // Next-state decode and counter control.
    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    state_nxt = ST_LOAD;
                    cnt_load  = 1'b1;
                end
            end
            ST_LOAD:  state_nxt = ERR ? ST_DONE : ST_SHIFT;
            ST_SHIFT: state_nxt = ST_CHECK;
            ST_CHECK: begin
                cnt_dec   = 1'b1;
                state_nxt = cnt_one ? ST_DONE : ST_SHIFT;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State register with Moore outputs registered from the next state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
            INIT  <= 1'b0;
            SH    <= 1'b0;
            Z     <= 1'b1;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            ERR   <= 1'b0;
        end else begin
            state <= state_nxt;
            INIT  <= (state_nxt == ST_LOAD);
            SH    <= (state_nxt == ST_SHIFT);
            Z     <= (state_nxt != ST_CHECK);
            BUSY  <= (state_nxt == ST_LOAD) || (state_nxt == ST_SHIFT) ||
                     (state_nxt == ST_CHECK);
            DONE  <= (state_nxt == ST_DONE);
            if (accept) begin
                ERR <= (DVSR == '0);
            end
        end
    end

    // Mealy quotient outputs: a non-negative difference means subtract.
    assign LDA = (state == ST_CHECK) && !MSB;
    assign DV0 = (state == ST_CHECK) && !MSB;

endmodule

// File: tb/tb_div_control_fsm.sv
// Directed bench: control FSM driving a behavioural shift/subtract datapath.
module tb_div_control_fsm;

    logic        CLK;
    logic        RST;
    logic        START;
    logic [15:0] DVSR;
    logic        MSB;
    logic        INIT, SH, LDA, DV0, Z, BUSY, DONE, ERR;

    logic [15:0] dividend;
    logic [16:0] a_reg;
    logic [15:0] dv_reg;
    logic [16:0] diff;
    logic [7:0]  outs;

    int n_checks = 0;
    int n_fail   = 0;

    int          init_at, done_at, done_cnt, busy_cnt, busy_first, busy_last, lda_cnt;
    logic [15:0] r_at_done;
    logic [16:0] a_at_done;
    logic        err_at_done;

    div_control_fsm dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .DVSR  (DVSR),
        .MSB   (MSB),
        .INIT  (INIT),
        .SH    (SH),
        .LDA   (LDA),
        .DV0   (DV0),
        .Z     (Z),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .ERR   (ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    assign diff = a_reg - {1'b0, DVSR};
    assign MSB  = diff[16];
    assign outs = {INIT, SH, LDA, DV0, Z, BUSY, DONE, ERR};

    // Restoring-divider datapath: A is remainder, DV becomes the quotient R.
    always_ff @(posedge CLK) begin
        if (INIT) begin
            a_reg  <= '0;
            dv_reg <= dividend;
        end else if (SH) begin
            {a_reg, dv_reg} <= {a_reg[15:0], dv_reg, 1'b0};
        end else if (!Z) begin
            if (LDA) a_reg <= diff;
            dv_reg[0] <= DV0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents an operation so that the next rising edge (edge 0) samples START;
    // returns at the falling edge inside cycle 1.
    task automatic start_op(input logic [15:0] dvd, input logic [15:0] dvs);
        @(negedge CLK);
        dividend = dvd;
        DVSR     = dvs;
        START    = 1'b1;
        @(negedge CLK);
        START    = 1'b0;
    endtask

    // Samples cycles 1..40 at the falling edge; optional stray START pulses.
    task automatic observe(input int p1, input int p2, input bit stop_on_done);
        init_at = 0; done_at = 0; done_cnt = 0; busy_cnt = 0;
        busy_first = 0; busy_last = 0; lda_cnt = 0;
        r_at_done = '0; a_at_done = '0; err_at_done = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge CLK);
            if (INIT && init_at == 0) init_at = c;
            if (BUSY) begin
                busy_cnt++;
                if (busy_first == 0) busy_first = c;
                busy_last = c;
            end
            if (LDA) lda_cnt++;
            if (DONE) begin
                done_cnt++;
                if (done_at == 0) begin
                    done_at     = c;
                    r_at_done   = dv_reg;
                    a_at_done   = a_reg;
                    err_at_done = ERR;
                end
            end
            START = (c == p1) || (c == p2);
            if (stop_on_done && done_cnt > 0) break;
        end
        START = 1'b0;
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; DVSR = '0; dividend = '0;
        #1;
        check_eq("reset_outputs", 32'(outs), 32'h08);
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        // 100 / 7
        start_op(16'd100, 16'd7);
        observe(0, 0, 1'b0);
        check_eq("d100_7_R", 32'(r_at_done), 32'd14);
        check_eq("d100_7_A", 32'(a_at_done), 32'd2);
        check_eq("d100_7_done_at", done_at, 34);
        check_eq("d100_7_done_cnt", done_cnt, 1);
        check_eq("d100_7_busy_first", busy_first, 1);
        check_eq("d100_7_busy_last", busy_last, 33);
        check_eq("d100_7_busy_cnt", busy_cnt, 33);
        check_eq("d100_7_err", 32'(err_at_done), 0);

        // 0xFFFF / 1
        start_op(16'hFFFF, 16'd1);
        observe(0, 0, 1'b0);
        check_eq("dffff_1_R", 32'(r_at_done), 32'hFFFF);
        check_eq("dffff_1_A", 32'(a_at_done), 32'd0);
        check_eq("dffff_1_lda_cnt", lda_cnt, 16);

        // 5 / 0
        start_op(16'd5, 16'd0);
        observe(0, 0, 1'b0);
        check_eq("dz_init_at", init_at, 1);
        check_eq("dz_done_at", done_at, 2);
        check_eq("dz_err_at_done", 32'(err_at_done), 1);
        check_eq("dz_busy_cnt", busy_cnt, 1);
        check_eq("dz_err_sticky", 32'(ERR), 1);
        start_op(16'd9, 16'd3);
        check_eq("dz_err_cleared", 32'(ERR), 0);
        observe(0, 0, 1'b0);
        check_eq("d9_3_R", 32'(r_at_done), 32'd3);
        check_eq("d9_3_A", 32'(a_at_done), 32'd0);

        // Stray START pulses during a run are ignored
        start_op(16'd100, 16'd7);
        observe(5, 20, 1'b0);
        check_eq("ign_R", 32'(r_at_done), 32'd14);
        check_eq("ign_A", 32'(a_at_done), 32'd2);
        check_eq("ign_done_at", done_at, 34);
        check_eq("ign_done_cnt", done_cnt, 1);

        // Asynchronous reset in the CHECK of cycle 15
        start_op(16'd100, 16'd7);
        repeat (14) @(negedge CLK);
        check_eq("rst_pre_z", 32'(Z), 0);
        check_eq("rst_pre_busy", 32'(BUSY), 1);
        RST = 1'b1;
        #1;
        check_eq("rst_mid_outputs", 32'(outs), 32'h08);
        @(negedge CLK);
        RST = 1'b0;
        start_op(16'd9, 16'd3);
        observe(0, 0, 1'b0);
        check_eq("rst_d9_3_R", 32'(r_at_done), 32'd3);
        check_eq("rst_d9_3_A", 32'(a_at_done), 32'd0);
        check_eq("rst_d9_3_done_at", done_at, 34);

        // Back-to-back: second START sampled in the IDLE cycle after DONE
        start_op(16'd100, 16'd7);
        observe(0, 0, 1'b1);
        check_eq("b2b1_done_at", done_at, 34);
        check_eq("b2b1_R", 32'(r_at_done), 32'd14);
        start_op(16'd8, 16'd3);
        observe(0, 0, 1'b0);
        check_eq("b2b2_busy_first", busy_first, 1);
        check_eq("b2b2_done_at", done_at, 34);
        check_eq("b2b2_R", 32'(r_at_done), 32'd2);
        check_eq("b2b2_A", 32'(a_at_done), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_control_fsm.md
# div_control_fsm

Control unit for the 16-bit restoring divider in the calculator core. Sequences the shift/subtract datapath through one load cycle and WIDTH shift-compare iterations, and generates the quotient bits. Drives the datapath's INIT, SH, LDA, DV0 and Z inputs and consumes the subtractor sign bit MSB. Exposes a START/BUSY/DONE handshake to the calculator top-level sequencer and flags divide-by-zero.

## Interface
- WIDTH, 16, operand width and iteration count.
- CNT_W, $clog2(WIDTH+1), iteration counter width.

Ports:
- CLK  in  1  clock, all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  request; sampled only in IDLE.
- DVSR  in  WIDTH  divisor; checked for zero only when START is accepted.
- MSB  in  1  sign of the subtractor result (A − DVSR); 1 = negative, so no subtract.
- INIT  out  1  datapath load/clear.
- SH  out  1  shift {A,DV} left.
- LDA  out  1  load A from the subtractor.
- DV0  out  1  quotient bit shifted into R.
- Z  out  1  append inhibit: 0 only in CHECK, 1 in every other state.
- BUSY  out  1  high from the LOAD state through the last CHECK state.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  divide-by-zero; sticky until the next accepted START.

## Operation
- States: IDLE, LOAD, SHIFT, CHECK, DONE.
- IDLE: if START is high, go to LOAD. The counter loads WIDTH. ERR is set to (DVSR==0), otherwise cleared.
- LOAD: INIT=1. If ERR=1, go to DONE. Otherwise go to SHIFT.
- SHIFT: SH=1, then go to CHECK.
- CHECK: SH=0 and Z=0.
  - If MSB=0: LDA=1 and DV0=1 (restore skipped, A takes the difference, quotient bit is 1).
  - If MSB=1: LDA=0 and DV0=0. The datapath appends 0 through its MSB&&!Z path.
  - The counter decrements. If the counter was 1, go to DONE. Otherwise go back to SHIFT.
- DONE: DONE=1 for one cycle, then go to IDLE. The quotient is in R and the remainder in A.
- LDA and DV0 are Mealy outputs: they are combinational on MSB in CHECK only. In every other state they are 0. All other outputs are decoded from the registered state.
- Z must be 1 outside CHECK. This keeps the datapath from appending stray bits while MSB floats.
- START while BUSY or in DONE: ignored, with no queuing.
- RST at any time: state goes to IDLE and the counter to 0.
  - Output values during reset: INIT=0, SH=0, LDA=0, DV0=0, Z=1, BUSY=0, DONE=0, ERR=0.
  - The datapath contents are don't-care until the next INIT.
- An unreachable state encoding returns to IDLE on the next edge.

## Timing
- Take the edge that samples START as edge 0. Then:
  - LOAD occupies cycle 1.
  - Iteration k (k=1..WIDTH) has SHIFT in cycle 2k and CHECK in cycle 2k+1.
  - DONE occupies cycle 2·WIDTH+2, which is cycle 34 for WIDTH=16.
- Divide-by-zero: LOAD in cycle 1, DONE with ERR=1 in cycle 2.
- Back-to-back: the earliest next START is sampled in the IDLE cycle after DONE. Minimum period is 2·WIDTH+3 cycles.
- MSB must be valid combinationally in CHECK. It is registered from A, and A settles at the SHIFT edge.

## Structure
- Shared package div_pkg holds:
  - the state encoding localparams (IDLE=0, LOAD=1, SHIFT=2, CHECK=3, DONE=4, 3-bit);
  - the default WIDTH;
  - the CNT_W expression.
- One sub-module, div_iter_counter: a loadable down-counter with a terminal-one flag, instantiated once.
- The FSM next-state and output decode live in the top module.
- The top-level testbench instantiates this block together with the shift datapath and a subtractor.

## Test plan
- 100 / 7, WIDTH=16, with the real datapath:
  - R=14 and A=2 at DONE;
  - DONE high in cycle 34 only;
  - BUSY high in cycles 1–33.
- 0xFFFF / 1: R=0xFFFF, A=0. LDA is high in all 16 CHECK cycles.
- 5 / 0:
  - INIT in cycle 1, DONE and ERR=1 in cycle 2;
  - ERR stays 1 in IDLE until the next START with a non-zero DVSR clears it.
- START pulsed in cycles 5 and 20 during a 100 / 7 run: ignored, and the result and DONE timing are unchanged.
- RST asserted mid-CHECK in cycle 15:
  - all outputs take their reset values in that cycle, asynchronously, with Z=1;
  - a subsequent 9 / 3 completes with R=3, A=0.
- Back-to-back 100 / 7 then 8 / 3: the second START is accepted in the cycle after DONE, giving R=2, A=2.
